uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the board's UART_RX pin, the inbound counterpart of the UART_TX path. It oversamples the line at 16x the baud rate, using an enable tick from a shared `mod_m_counter`, and recovers 8N1-style frames. Each received word is presented on a valid/ready output register that feeds the display and command logic. It also flags framing errors and overruns.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, sent LSB first.
- `SB_TICK`, 16: oversample ticks spent in the stop bit. Use 16 for 1 stop bit, 24 for 1.5, 32 for 2.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line, asynchronous to `clk`. Idles high.
- `s_tick`  in  1  one-`clk` pulse at 16x baud (`max_tick` of `mod_m_counter`).
- `rx_data`  out  DBIT  last accepted data word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts the word in any cycle where `rx_valid` and `rx_ready` are both high.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good frame completed while the previous word was still unconsumed.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer (`rx_s`) with reset value 1. All FSM decisions use `rx_s`.
- **Registers:**
  - State: IDLE, START, DATA, STOP.
  - `s` is a 4-bit tick counter. Wide enough for SB_TICK up to 16; widen it if SB_TICK is 24 or 32.
  - `n` is a ceil(log2(DBIT))-bit bit counter.
  - `b` is a DBIT-bit shift register.
- **IDLE:** when `rx_s`==0, go to START and set `s`=0. `s_tick` is not required for this transition.
- **START:** act only on cycles with `s_tick`.
  - If `s`==7 and `rx_s`==0: go to DATA, set `s`=0, `n`=0.
  - If `s`==7 and `rx_s`==1: glitch. Return to IDLE with no flags.
  - Otherwise `s`++.
- **DATA:** act only on `s_tick`.
  - If `s`==15: set `b` = {`rx_s`, `b[DBIT-1:1]`}, then `s`=0. If `n`==DBIT-1, go to STOP; otherwise `n`++.
  - Otherwise `s`++.
- **STOP:** act only on `s_tick`.
  - If `s`==SB_TICK-1: go to IDLE. If `rx_s`==1 the frame is good; if 0, pulse `frame_err` and discard `b`.
  - Otherwise `s`++.
- **Delivery of a good frame:**
  - If `rx_valid`==0, or `rx_valid`&&`rx_ready` in the same cycle: load `rx_data`<=`b` and keep `rx_valid`=1.
  - Otherwise pulse `overrun`, drop the new word, and keep the old `rx_data` and `rx_valid`=1.
- **Consume:** `rx_valid`&&`rx_ready` with no simultaneous delivery clears `rx_valid` on the next edge. `rx_data` holds its last value.
- **Reset values:** state IDLE, `s`/`n`/`b`=0, synchronizer flops = 1, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- **Reset mid-frame:** the partial frame is abandoned and no flag is raised. After release, the receiver resyncs on the next high-to-low edge of `rx_s`.
- **Line held low (break):** produces `frame_err` once, re-enters START immediately from IDLE, and repeats for every frame-length period.

## Timing
- `rx` to `rx_s`: 2 `clk` cycles.
- START midpoint check: 8 ticks after the falling edge is seen. Each data bit is then sampled 16 ticks later, at bit centre.
- `rx_valid` rises on the `clk` edge after the STOP sample tick. Total latency from the start edge is about (8 + 16·DBIT + SB_TICK) ticks + 3 clk.
- `frame_err` and `overrun` are high for exactly one `clk`, on the same edge where `rx_valid` would have been loaded.
- `busy`=1 from the edge entering START until the edge returning to IDLE.
- No combinational path from `rx` or `rx_ready` to any output. All outputs are registered.
- Ready may be held high permanently; each word then gets exactly one valid cycle.

## Test plan
Common setup: `s_tick` every 4 `clk` (64 clk/bit), DBIT=8, SB_TICK=16, `rx_ready`=1 unless stated.
- **Single frame:** send 0x55 → `rx_data`=0x55, `rx_valid` high 1 cycle, no flags, `busy` low after the stop bit.
- **Back-to-back:** send 0x00, 0xFF, 0xA5 with no idle gap → three valid cycles with 0x00, 0xFF, 0xA5 in order.
- **Framing error:** send 0x3C with the stop bit low → one `frame_err` pulse, `rx_valid` stays 0. A following 0x81 with a proper stop bit is received correctly.
- **Glitch and overrun:**
  - Glitch: a 20-clk low pulse on idle `rx` → returns to IDLE after the START check, no output.
  - Overrun: `rx_ready`=0, send 0x11 then 0x22 → `rx_data`=0x11, one `overrun` pulse. Raising `rx_ready` clears `rx_valid`.
- **Simultaneous consume:** with `rx_valid`=1 (0x11), raise `rx_ready` in the same cycle a 0x22 frame completes → `rx_data`=0x22, `rx_valid` stays 1, no `overrun`.
- **Reset mid-frame:** assert `reset` during data bit 4 → all outputs 0 immediately. After release, send 0xC3 → received cleanly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 16x oversampling serial receiver for 8N1-style frames.
//
// The raw line is synchronised, a falling edge starts a frame, the start bit is
// confirmed at its midpoint and each data bit (LSB first) is then sampled at its
// centre. A completed frame is handed to a valid/ready output register.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   rx         in   raw serial line (async to clk, idles high)
//   s_tick     in   one-clk enable pulse at 16x baud
//   rx_data    out  last accepted data word (DBIT bits)
//   rx_valid   out  rx_data holds an unconsumed word
//   rx_ready   in   consumer accepts when rx_valid && rx_ready
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: good frame dropped, previous word unconsumed
//   busy       out  receiver is inside a frame (not idle)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  // Tick counter must reach both 15 (data bits) and SB_TICK-1 (stop bit).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            rx_meta_q, rx_s_q;
  logic            stop_done;

  logic [DBIT-1:0] rx_data_q;
  logic            rx_valid_q, frame_err_q, overrun_q, busy_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    stop_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A falling edge starts the frame immediately, without waiting for a tick.
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == SW'(7)) begin
            // Midpoint of the start bit: still low means a real frame,
            // high means the edge was a glitch and is ignored.
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d   = IDLE;
            stop_done = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: delivery, consume, and the one-cycle flag pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= stop_done & ~rx_s_q;
      overrun_q   <= 1'b0;
      busy_q      <= (state_d != IDLE);
      if (stop_done && rx_s_q) begin
        // A word being consumed this very cycle frees the slot for the new one.
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= b_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (DBIT=8, SB_TICK=16,
// s_tick every 4 clk, 64 clk per bit). A reference model predicts, per frame
// sent, which word should be handed over, and how many framing-error and
// overrun pulses should appear; a monitor checks every handshake against it.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BITCLK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .s_tick    (s_tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // 16x-baud enable: one clk high out of every four.
  logic [1:0] tick_cnt = 2'd0;
  always @(negedge clk) begin
    tick_cnt = tick_cnt + 2'd1;
    s_tick   = (tick_cnt == 2'd0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counters and reference model state.
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0;
  int fe_seen = 0, ov_seen = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A good frame is kept if the output slot is free or is being emptied at
  // delivery time; otherwise it is dropped and counts as an overrun.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit ready_at_end);
    if (!stop_ok)                                exp_fe++;
    else if (exp_q.size() == 0 || ready_at_end)  exp_q.push_back(d);
    else                                         exp_ov++;
  endtask

  // Monitor: samples just after the bench has driven its inputs for the cycle.
  always @(negedge clk) begin
    #2;
    if (rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_valid;
    if (frame_err) fe_seen++;
    if (overrun)   ov_seen++;
    if (rx_valid && rx_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {24'd0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check_eq("rx_data", {24'd0, rx_data}, {24'd0, e});
        $display("word 0x%02h expected 0x%02h at cycle %0d", rx_data, e, cyc);
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit ready_at_end);
    model_frame(d, stop_ok, ready_at_end);
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BITCLK) @(negedge clk);
    end else begin
      // Low across the stop-bit sample point, then back to idle.
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic align_tick();
    do begin
      @(negedge clk);
      #1;
    end while (tick_cnt != 2'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"},  {24'd0, rx_data}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check_eq({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check_eq({tag, "_ovr"},   {31'd0, overrun}, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  int s1, s2, lat, k;
  logic [7:0] rd;
  bit good;

  initial begin
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Single frame.
    send_frame(8'h55, 1'b1, 1'b1);
    #1;
    check_eq("single_busy", {31'd0, busy}, 32'd0);
    check_eq("single_data", {24'd0, rx_data}, 32'h55);
    repeat (20) @(negedge clk);

    // Back-to-back frames.
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (100) @(negedge clk);

    // Framing error, then a clean frame.
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (128) @(negedge clk);
    check_eq("ferr_count", fe_seen, exp_fe);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (100) @(negedge clk);

    // Short glitch on an idle line.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    check_eq("glitch_busy", {31'd0, busy}, 32'd0);
    check_eq("glitch_ferr", fe_seen, exp_fe);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check_eq("ovr_data",  {24'd0, rx_data}, 32'h11);
    check_eq("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("ovr_count", ov_seen, exp_ov);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("ovr_cleared", {31'd0, rx_valid}, 32'd0);

    // Simultaneous consume and delivery. The delivery latency of the first
    // (phase-aligned) frame is reused to place the ready rise exactly.
    rx_ready = 1'b0;
    align_tick();
    s1 = cyc;
    send_frame(8'h11, 1'b1, 1'b0);
    lat = last_rise - s1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("sim_hold", {31'd0, rx_valid}, 32'd1);
    align_tick();
    s2 = cyc;
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        k = 0;
        while (cyc < s2 + lat - 1 && k < 2000) begin
          @(negedge clk);
          k++;
        end
        #1;
        rx_ready = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    #1;
    check_eq("sim_data", {24'd0, rx_data}, 32'h22);
    check_eq("sim_ovr",  ov_seen, exp_ov);

    // Randomised frames: random data, gaps and occasional bad stop bits.
    for (int f = 0; f < 12; f++) begin
      rd   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 4) != 0);
      send_frame(rd, good, 1'b1);
      k = $urandom_range(0, 2);
      if (!good && k == 0) k = 1;
      repeat (k * BITCLK) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    check_eq("rand_ferr", fe_seen, exp_fe);

    // Reset during data bit 4, then a clean frame.
    rd = 8'hA6;
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = rd[i];
      repeat (BITCLK) @(negedge clk);
    end
    rx = rd[4];
    repeat (32) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    #1;
    check_eq("final_data",  {24'd0, rx_data}, 32'hC3);
    check_eq("final_left",  exp_q.size(), 32'd0);
    check_eq("final_ferr",  fe_seen, exp_fe);
    check_eq("final_ovr",   ov_seen, exp_ov);
    check_eq("final_busy",  {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
